// File: rtl/mem_copy_ctrl.sv
// mem_copy_ctrl: arbitrates the data memory port between CPU load/store and a byte-wise block-copy engine.
// The copy engine stalls the CPU and spends one read cycle plus one write cycle per byte.
module mem_copy_ctrl #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    input  logic         CpuWriteEn,
    input  logic [A-1:0] CpuAddr,
    input  logic [A-1:0] CpuOffset,
    input  logic [W-1:0] CpuDataIn,
    output logic [W-1:0] CpuDataOut,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddr,
    output logic [A-1:0] MemOffset,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut,
    output logic         Busy,
    output logic         Done,
    output logic         CpuStall
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};

    state_t       state, state_next;
    logic [A-1:0] src, dst, len, idx;
    logic [W-1:0] hold;
    logic         last;

    assign last       = (idx + ONE) == len;
    assign Busy       = (state == READ) || (state == WRITE);
    assign Done       = state == DONE;
    assign CpuStall   = Busy;
    assign CpuDataOut = MemDataOut;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            src   <= '0;
            dst   <= '0;
            len   <= '0;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && Start) begin
                src <= SrcAddr;
                dst <= DstAddr;
                len <= Len;
                idx <= '0;
            end
            if (state == READ)
                hold <= MemDataOut;
            if (state == WRITE && !last)
                idx <= idx + ONE;
        end
    end

    // Engine owns the port only in READ/WRITE; CPU stores issued then are dropped.
    always_comb begin
        state_next = state;
        MemWriteEn = CpuWriteEn;
        MemAddr    = CpuAddr;
        MemOffset  = CpuOffset;
        MemDataIn  = CpuDataIn;
        case (state)
            IDLE:  state_next = Start ? ((Len != '0) ? READ : DONE) : IDLE;
            READ: begin
                MemWriteEn = 1'b0;
                MemAddr    = src + idx;
                MemOffset  = '0;
                MemDataIn  = hold;
                state_next = WRITE;
            end
            WRITE: begin
                MemWriteEn = 1'b1;
                MemAddr    = dst + idx;
                MemOffset  = '0;
                MemDataIn  = hold;
                state_next = last ? DONE : READ;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_copy_ctrl.sv
// tb_mem_copy_ctrl: directed bench for mem_copy_ctrl with a behavioural 256x8 memory attached.
module tb_mem_copy_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_addr, dst_addr, len;
    logic       cpu_we;
    logic [7:0] cpu_addr, cpu_off, cpu_din, cpu_dout;
    logic       mem_we;
    logic [7:0] mem_addr, mem_off, mem_din, mem_dout;
    logic       busy, done, cpu_stall;

    logic [7:0] core [256];
    logic [7:0] eff;
    logic       load_mem;

    int checks = 0;
    int errors = 0;
    int cyc, busy_cnt, stall_cnt, done_cnt, done_at, we_cnt;

    always #5 clk = ~clk;

    mem_copy_ctrl #(.W(8), .A(8)) dut (
        .Clk(clk), .Reset(rst), .Start(start),
        .SrcAddr(src_addr), .DstAddr(dst_addr), .Len(len),
        .CpuWriteEn(cpu_we), .CpuAddr(cpu_addr), .CpuOffset(cpu_off),
        .CpuDataIn(cpu_din), .CpuDataOut(cpu_dout),
        .MemWriteEn(mem_we), .MemAddr(mem_addr), .MemOffset(mem_off),
        .MemDataIn(mem_din), .MemDataOut(mem_dout),
        .Busy(busy), .Done(done), .CpuStall(cpu_stall)
    );

    // Memory: effective address is base + offset, combinational read, synchronous write.
    assign eff      = mem_addr + mem_off;
    assign mem_dout = core[eff];

    always @(posedge clk) begin
        if (load_mem)
            for (int i = 0; i < 256; i++) core[i] <= 8'(i);
        else if (mem_we)
            core[eff] <= mem_din;
    end

    task automatic init_mem();
        load_mem = 1'b1;
        @(posedge clk); #1;
        load_mem = 1'b0;
    endtask

    task automatic start_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n);
        src_addr = s; dst_addr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; busy_cnt = 0; stall_cnt = 0; done_cnt = 0; done_at = -1; we_cnt = 0;
    endtask

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            cyc++;
            @(negedge clk);
            busy_cnt  += int'(busy);
            stall_cnt += int'(cpu_stall);
            we_cnt    += int'(mem_we);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; load_mem = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        cpu_we = 1'b0; cpu_addr = 8'h07; cpu_off = 8'h03; cpu_din = 8'h00;
        @(posedge clk); #1;
        init_mem();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, cpu_stall} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, cpu_stall}); end
        checks++; if (mem_addr !== 8'h07 || mem_off !== 8'h03) begin errors++; $display("FAIL reset_passthru_addr: got %h/%h want 07/03", mem_addr, mem_off); end
        checks++; if (cpu_dout !== 8'h0A) begin errors++; $display("FAIL reset_cpu_dout: got %h want 0a", cpu_dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        init_mem();
        start_copy(8'h10, 8'h80, 8'd4);
        observe(12);
        checks++; if (busy_cnt !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
        checks++; if (stall_cnt !== 8) begin errors++; $display("FAIL basic_stall_cycles: got %0d want 8", stall_cnt); end
        checks++; if (done_at !== 9) begin errors++; $display("FAIL basic_done_cycle: got %0d want 9", done_at); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        checks++; if (we_cnt !== 4) begin errors++; $display("FAIL basic_writes: got %0d want 4", we_cnt); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h10 + 8'(i);
            checks++; if (core[8'h80 + i] !== exp) begin errors++; $display("FAIL basic_dst[%0d]: got %h want %h", i, core[8'h80 + i], exp); end
        end
        checks++; if (core[8'h84] !== 8'h84) begin errors++; $display("FAIL basic_past_end: got %h want 84", core[8'h84]); end
    endtask

    task automatic test_len_zero();
        start_copy(8'h22, 8'h33, 8'd0);
        observe(4);
        checks++; if (done_at !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d want 1", done_at); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_count: got %0d want 1", done_cnt); end
        checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL len0_busy: got %0d want 0", busy_cnt); end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL len0_writes: got %0d want 0", we_cnt); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp [4];
        exp[0] = 8'hFE; exp[1] = 8'hFF; exp[2] = 8'h00; exp[3] = 8'h01;
        init_mem();
        start_copy(8'hFE, 8'h40, 8'd4);
        observe(11);
        for (int i = 0; i < 4; i++) begin
            checks++; if (core[8'h40 + i] !== exp[i]) begin errors++; $display("FAIL wrap_dst[%0d]: got %h want %h", i, core[8'h40 + i], exp[i]); end
        end
    endtask

    task automatic test_cpu_stall();
        init_mem();
        start_copy(8'h30, 8'h60, 8'd3);
        cpu_we = 1'b1; cpu_addr = 8'h20; cpu_off = 8'h05; cpu_din = 8'hAA;
        observe(6);
        checks++; if (stall_cnt !== 6) begin errors++; $display("FAIL stall_cycles: got %0d want 6", stall_cnt); end
        checks++; if (we_cnt !== 3) begin errors++; $display("FAIL stall_writes: got %0d want 3", we_cnt); end
        checks++; if (core[8'h25] !== 8'h25) begin errors++; $display("FAIL stall_store_dropped: got %h want 25", core[8'h25]); end
        observe(1);
        cpu_we = 1'b0;
        checks++; if (done_at !== 7) begin errors++; $display("FAIL stall_done_cycle: got %0d want 7", done_at); end
        checks++; if (core[8'h25] !== 8'hAA) begin errors++; $display("FAIL stall_store_after: got %h want aa", core[8'h25]); end
        checks++; if (core[8'h62] !== 8'h32) begin errors++; $display("FAIL stall_copy_last: got %h want 32", core[8'h62]); end
    endtask

    task automatic test_restart_ignored();
        init_mem();
        start_copy(8'h10, 8'h90, 8'd4);
        observe(1);
        src_addr = 8'h50; dst_addr = 8'hA0; len = 8'd2; start = 1'b1;
        observe(3);
        start = 1'b0;
        observe(10);
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_at !== 9) begin errors++; $display("FAIL restart_done_cycle: got %0d want 9", done_at); end
        checks++; if (we_cnt !== 4) begin errors++; $display("FAIL restart_writes: got %0d want 4", we_cnt); end
        checks++; if (core[8'h93] !== 8'h13) begin errors++; $display("FAIL restart_orig_last: got %h want 13", core[8'h93]); end
        checks++; if (core[8'hA0] !== 8'hA0 || core[8'hA1] !== 8'hA1) begin errors++; $display("FAIL restart_other_range: got %h %h want a0 a1", core[8'hA0], core[8'hA1]); end
    endtask

    task automatic test_overlap();
        init_mem();
        start_copy(8'h10, 8'h11, 8'd3);
        observe(9);
        for (int i = 1; i <= 3; i++) begin
            checks++; if (core[8'h10 + i] !== 8'h10) begin errors++; $display("FAIL overlap_dst[%0d]: got %h want 10", i, core[8'h10 + i]); end
        end
        checks++; if (core[8'h14] !== 8'h14) begin errors++; $display("FAIL overlap_past_end: got %h want 14", core[8'h14]); end
    endtask

    task automatic test_reset_mid_copy();
        init_mem();
        start_copy(8'h20, 8'hB0, 8'd8);
        observe(4);
        rst = 1'b1;
        observe(1);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle_next: got busy=%b want 0", busy); end
        @(posedge clk); #1;
        observe(12);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midreset_done_count: got %0d want 0", done_cnt); end
        checks++; if (we_cnt !== 2) begin errors++; $display("FAIL midreset_writes: got %0d want 2", we_cnt); end
        checks++; if (busy_cnt !== 5) begin errors++; $display("FAIL midreset_busy_cycles: got %0d want 5", busy_cnt); end
        checks++; if (core[8'hB0] !== 8'h20 || core[8'hB1] !== 8'h21) begin errors++; $display("FAIL midreset_written: got %h %h want 20 21", core[8'hB0], core[8'hB1]); end
        checks++; if (core[8'hB2] !== 8'hB2) begin errors++; $display("FAIL midreset_untouched: got %h want b2", core[8'hB2]); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_cpu_stall();
        test_restart_ignored();
        test_overlap();
        test_reset_mid_copy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
